// File: rtl/issueque_int.sv
`default_nettype none
// ============================================================================
//  Module   : issueque_int
//  Purpose  : Age-ordered integer issue queue. Entry 0 is the oldest. Entries
//             wake up from CDB broadcasts, the oldest fully-ready entry is
//             offered to the ALU, and younger entries compact down on issue.
//  Revision : 1.0  initial release
// ============================================================================
module issueque_int #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_en,
  input  logic [2:0]       dispatch_opcode,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  input  logic [31:0]      dispatch_rs_data,
  input  logic [31:0]      dispatch_rt_data,
  input  logic [TAG_W-1:0] dispatch_rs_tag,
  input  logic [TAG_W-1:0] dispatch_rt_tag,
  input  logic             dispatch_rs_ready,
  input  logic             dispatch_rt_ready,
  output logic             full,
  output logic [2:0]       count,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             issue_valid,
  output logic [2:0]       issue_opcode,
  output logic [TAG_W-1:0] issue_rd_tag,
  output logic [31:0]      issue_rs_data,
  output logic [31:0]      issue_rt_data,
  input  logic             issue_rdy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic [TAG_W-1:0] rs_tag;
    logic [TAG_W-1:0] rt_tag;
    logic             rs_rdy;
    logic             rt_rdy;
  } entry_t;

  logic [DEPTH-1:0] r_valid;
  entry_t           r_ent [DEPTH];
  logic [DEPTH-1:0] n_valid;
  entry_t           n_ent [DEPTH];

  // One extra, always-empty slot above the top so the shift mux needs no
  // special case for the highest entry.
  logic [DEPTH:0]   ext_valid;
  entry_t           ext_ent [DEPTH+1];

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             fire;
  logic             accept;
  logic [2:0]       wr_idx;
  entry_t           disp_ent;

  assign ext_valid = {1'b0, r_valid};
  assign ext_ent[DEPTH] = '0;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ext
    assign ext_ent[gi] = r_ent[gi];
  end

  // Occupancy: valid entries are always packed at the bottom, so a popcount
  // equals the write pointer.
  always_comb begin
    count = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + {2'b00, r_valid[i]};
    end
  end

  assign full = (count == 3'(DEPTH));

  // Oldest entry with both operands ready wins the select.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && r_valid[i] && r_ent[i].rs_rdy && r_ent[i].rt_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Issue port is driven from registered state only; zero when idle.
  always_comb begin
    issue_valid   = 1'b0;
    issue_opcode  = '0;
    issue_rd_tag  = '0;
    issue_rs_data = '0;
    issue_rt_data = '0;
    if (sel_found) begin
      issue_valid   = 1'b1;
      issue_opcode  = r_ent[sel_idx].opcode;
      issue_rd_tag  = r_ent[sel_idx].rd_tag;
      issue_rs_data = r_ent[sel_idx].rs_data;
      issue_rt_data = r_ent[sel_idx].rt_data;
    end
  end

  assign fire   = issue_valid && issue_rdy;
  assign accept = dispatch_en && !full && !flush;
  assign wr_idx = fire ? (count - 3'd1) : count;

  // Incoming instruction, with same-cycle CDB capture for non-ready operands.
  always_comb begin
    disp_ent         = '0;
    disp_ent.opcode  = dispatch_opcode;
    disp_ent.rd_tag  = dispatch_rd_tag;
    disp_ent.rs_tag  = dispatch_rs_tag;
    disp_ent.rt_tag  = dispatch_rt_tag;
    disp_ent.rs_rdy  = dispatch_rs_ready;
    disp_ent.rt_rdy  = dispatch_rt_ready;
    disp_ent.rs_data = dispatch_rs_data;
    disp_ent.rt_data = dispatch_rt_data;
    if (cdb_valid && !dispatch_rs_ready && (dispatch_rs_tag == cdb_tag)) begin
      disp_ent.rs_rdy  = 1'b1;
      disp_ent.rs_data = cdb_data;
    end
    if (cdb_valid && !dispatch_rt_ready && (dispatch_rt_tag == cdb_tag)) begin
      disp_ent.rt_rdy  = 1'b1;
      disp_ent.rt_data = cdb_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic   shift;
    entry_t nxt;
    logic   nxt_v;

    assign shift = fire && (sel_idx <= IDX_W'(gi));

    // Per-slot next state: pick self or the slot above, apply wakeup, then
    // let an accepted dispatch overwrite the slot it targets.
    always_comb begin
      nxt   = shift ? ext_ent[gi+1]   : ext_ent[gi];
      nxt_v = shift ? ext_valid[gi+1] : ext_valid[gi];
      if (cdb_valid && !nxt.rs_rdy && (nxt.rs_tag == cdb_tag)) begin
        nxt.rs_rdy  = 1'b1;
        nxt.rs_data = cdb_data;
      end
      if (cdb_valid && !nxt.rt_rdy && (nxt.rt_tag == cdb_tag)) begin
        nxt.rt_rdy  = 1'b1;
        nxt.rt_data = cdb_data;
      end
      if (accept && (wr_idx == 3'(gi))) begin
        nxt   = disp_ent;
        nxt_v = 1'b1;
      end
    end

    assign n_ent[gi]   = nxt;
    assign n_valid[gi] = nxt_v;
  end

  // Valid bits: asynchronous reset, flush wins over everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= n_valid;
    end
  end

  // Payload carries no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    r_ent <= n_ent;
  end

endmodule
`default_nettype wire

// File: tb/tb_issueque_int.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issueque_int
//  Purpose  : Self-checking bench for issueque_int; a queue-based reference
//             model predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issueque_int;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst, flush, dispatch_en;
  logic [2:0]       dispatch_opcode;
  logic [TAG_W-1:0] dispatch_rd_tag, dispatch_rs_tag, dispatch_rt_tag;
  logic [31:0]      dispatch_rs_data, dispatch_rt_data;
  logic             dispatch_rs_ready, dispatch_rt_ready;
  logic             full;
  logic [2:0]       count;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_valid;
  logic [2:0]       issue_opcode;
  logic [TAG_W-1:0] issue_rd_tag;
  logic [31:0]      issue_rs_data, issue_rt_data;
  logic             issue_rdy;

  issueque_int #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dispatch_en(dispatch_en),
    .dispatch_opcode(dispatch_opcode), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs_data(dispatch_rs_data), .dispatch_rt_data(dispatch_rt_data),
    .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rt_tag(dispatch_rt_tag),
    .dispatch_rs_ready(dispatch_rs_ready), .dispatch_rt_ready(dispatch_rt_ready),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_rd_tag(issue_rd_tag), .issue_rs_data(issue_rs_data),
    .issue_rt_data(issue_rt_data), .issue_rdy(issue_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [TAG_W-1:0] rd;
    logic [31:0]      rs_d, rt_d;
    logic [TAG_W-1:0] rs_t, rt_t;
    bit               rs_r, rt_r;
  } mentry_t;

  mentry_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output (and slot order) against the model queue.
  task automatic check_outputs(input string ctx);
    int sel = -1;
    foreach (q[i]) if (sel < 0 && q[i].rs_r && q[i].rt_r) sel = i;
    check_eq({ctx, "_count"}, 64'(count), 64'(q.size()));
    check_eq({ctx, "_full"}, 64'(full), 64'(q.size() == DEPTH));
    check_eq({ctx, "_ivalid"}, 64'(issue_valid), 64'(sel >= 0));
    if (sel >= 0) begin
      check_eq({ctx, "_iop"}, 64'(issue_opcode), 64'(q[sel].op));
      check_eq({ctx, "_ird"}, 64'(issue_rd_tag), 64'(q[sel].rd));
      check_eq({ctx, "_irs"}, 64'(issue_rs_data), 64'(q[sel].rs_d));
      check_eq({ctx, "_irt"}, 64'(issue_rt_data), 64'(q[sel].rt_d));
    end else begin
      check_eq({ctx, "_idle"}, {26'd0, issue_opcode, issue_rd_tag, issue_rs_data | issue_rt_data}, 64'd0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      check_eq({ctx, "_slotv"}, 64'(dut.r_valid[i]), 64'(i < q.size()));
      if (i < q.size()) check_eq({ctx, "_slotrd"}, 64'(dut.r_ent[i].rd_tag), 64'(q[i].rd));
    end
  endtask

  // Reference behaviour at a rising edge, expressed on an age-ordered list.
  task automatic model_edge();
    int sel = -1;
    bit fire, acc;
    mentry_t e;
    if (flush) begin
      q.delete();
      return;
    end
    foreach (q[i]) if (sel < 0 && q[i].rs_r && q[i].rt_r) sel = i;
    fire = (sel >= 0) && issue_rdy;
    acc  = dispatch_en && (q.size() < DEPTH);
    if (cdb_valid) begin
      foreach (q[i]) begin
        if (!q[i].rs_r && q[i].rs_t == cdb_tag) begin q[i].rs_r = 1; q[i].rs_d = cdb_data; end
        if (!q[i].rt_r && q[i].rt_t == cdb_tag) begin q[i].rt_r = 1; q[i].rt_d = cdb_data; end
      end
    end
    if (fire) q.delete(sel);
    if (acc) begin
      e.op = dispatch_opcode;    e.rd = dispatch_rd_tag;
      e.rs_d = dispatch_rs_data; e.rt_d = dispatch_rt_data;
      e.rs_t = dispatch_rs_tag;  e.rt_t = dispatch_rt_tag;
      e.rs_r = dispatch_rs_ready; e.rt_r = dispatch_rt_ready;
      if (cdb_valid && !e.rs_r && e.rs_t == cdb_tag) begin e.rs_r = 1; e.rs_d = cdb_data; end
      if (cdb_valid && !e.rt_r && e.rt_t == cdb_tag) begin e.rt_r = 1; e.rt_d = cdb_data; end
      q.push_back(e);
    end
  endtask

  task automatic step(input string ctx);
    #3;
    check_outputs(ctx);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    dispatch_en = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  // A ready operand takes *_v as data; a waiting operand takes it as a tag.
  task automatic disp(input logic [2:0] op, input logic [TAG_W-1:0] rd,
                      input bit rs_r, input logic [31:0] rs_v,
                      input bit rt_r, input logic [31:0] rt_v);
    dispatch_en       = 1'b1;
    dispatch_opcode   = op;
    dispatch_rd_tag   = rd;
    dispatch_rs_ready = rs_r;
    dispatch_rt_ready = rt_r;
    dispatch_rs_data  = rs_r ? rs_v : 32'hDEAD0000;
    dispatch_rt_data  = rt_r ? rt_v : 32'hDEAD0001;
    dispatch_rs_tag   = rs_v[TAG_W-1:0];
    dispatch_rt_tag   = rt_v[TAG_W-1:0];
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst = 1'b1; issue_rdy = 1'b0; cdb_tag = '0; cdb_data = '0;
    dispatch_opcode = '0; dispatch_rd_tag = '0; dispatch_rs_tag = '0; dispatch_rt_tag = '0;
    dispatch_rs_data = '0; dispatch_rt_data = '0; dispatch_rs_ready = 1'b0; dispatch_rt_ready = 1'b0;
    idle();
    #2;
    check_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ready dispatch issues the following cycle.
    issue_rdy = 1'b1;
    disp(3'd2, 6'd5, 1, 32'd10, 1, 32'd20);
    step("d37");
    check_eq("d37_valid", 64'(issue_valid), 64'd1);
    check_eq("d37_rs", 64'(issue_rs_data), 64'd10);
    check_eq("d37_rt", 64'(issue_rt_data), 64'd20);
    check_eq("d37_rd", 64'(issue_rd_tag), 64'd5);
    check_eq("d37_count", 64'(count), 64'd1);
    idle();
    step("d37b");

    // Wakeup one cycle after dispatch; no forwarding in the broadcast cycle.
    disp(3'd1, 6'd6, 1, 32'h11, 0, 32'd7);
    step("d38");
    idle();
    cdb(6'd7, 32'hABCD);
    check_eq("d38_bcast_valid", 64'(issue_valid), 64'd0);
    step("d38b");
    idle();
    check_eq("d38_valid", 64'(issue_valid), 64'd1);
    check_eq("d38_rt", 64'(issue_rt_data), 64'hABCD);
    step("d38c");

    // Dispatch/CDB collision in the same cycle.
    disp(3'd3, 6'd8, 0, 32'd9, 1, 32'h22);
    cdb(6'd9, 32'h55);
    step("d39");
    idle();
    check_eq("d39_valid", 64'(issue_valid), 64'd1);
    check_eq("d39_rs", 64'(issue_rs_data), 64'h55);
    step("d39b");

    // Fill, drop while full, then issue the only ready middle entry.
    issue_rdy = 1'b0;
    disp(3'd0, 6'd10, 0, 32'd20, 1, 32'd1); step("d40a");
    disp(3'd0, 6'd11, 0, 32'd21, 1, 32'd2); step("d40b");
    disp(3'd0, 6'd12, 1, 32'd3,  1, 32'd4); step("d40c");
    disp(3'd0, 6'd13, 0, 32'd23, 1, 32'd5); step("d40d");
    check_eq("d40_full", 64'(full), 64'd1);
    check_eq("d40_count", 64'(count), 64'd4);
    disp(3'd0, 6'd14, 1, 32'd6, 1, 32'd7); step("d40e");
    issue_rdy = 1'b1;
    step("d40f");
    check_eq("d40_count3", 64'(count), 64'd3);
    check_eq("d40_slot2", 64'(dut.r_ent[2].rd_tag), 64'd13);

    // Flush beats a simultaneous dispatch.
    flush = 1'b1;
    step("d42");
    check_eq("d42_count", 64'(count), 64'd0);
    check_eq("d42_full", 64'(full), 64'd0);
    check_eq("d42_valid", 64'(issue_valid), 64'd0);
    idle();

    // Issue and dispatch in the same cycle at count 2.
    issue_rdy = 1'b0;
    disp(3'd4, 6'd20, 0, 32'd30, 1, 32'd0); step("d41a");
    disp(3'd5, 6'd21, 1, 32'd1,  1, 32'd2); step("d41b");
    issue_rdy = 1'b1;
    disp(3'd6, 6'd22, 1, 32'd3,  1, 32'd4); step("d41c");
    check_eq("d41_count", 64'(count), 64'd2);
    check_eq("d41_slot1", 64'(dut.r_ent[1].rd_tag), 64'd22);
    idle();

    // Asynchronous reset mid-operation.
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_valid", 64'(issue_valid), 64'd0);
    check_eq("arst_data", 64'(issue_rs_data | issue_rt_data), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomised traffic with a small tag space to force wakeups/collisions.
    for (int c = 0; c < 600; c++) begin
      dispatch_en       = ($urandom_range(0, 3) != 0);
      dispatch_opcode   = 3'($urandom);
      dispatch_rd_tag   = TAG_W'($urandom);
      dispatch_rs_ready = 1'($urandom_range(0, 1));
      dispatch_rt_ready = 1'($urandom_range(0, 1));
      dispatch_rs_data  = $urandom;
      dispatch_rt_data  = $urandom;
      dispatch_rs_tag   = TAG_W'($urandom_range(0, 7));
      dispatch_rt_tag   = TAG_W'($urandom_range(0, 7));
      cdb_valid         = 1'($urandom_range(0, 1));
      cdb_tag           = TAG_W'($urandom_range(0, 7));
      cdb_data          = $urandom;
      issue_rdy         = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 39) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/issueque_int.md
ISSUEQUE_INT -- requirements
Module: issueque_int

Interface
REQ-001 DEPTH, 4, number of queue entries; entry 0 is always the oldest.
REQ-002 TAG_W, 6, width of physical/ROB tags carried by dispatch and the CDB.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  mispredict flush; empties the queue at the next edge.
REQ-006 dispatch_en  input  1  dispatch writes one instruction this cycle.
REQ-007 dispatch_opcode  input  3  ALU operation code.
REQ-008 dispatch_rd_tag  input  TAG_W  destination tag.
REQ-009 dispatch_rs_data / dispatch_rt_data  input  32 each  operand values, valid when the matching ready bit is 1.
REQ-010 dispatch_rs_tag / dispatch_rt_tag  input  TAG_W each  producer tags, used when the matching ready bit is 0.
REQ-011 dispatch_rs_ready / dispatch_rt_ready  input  1 each  operand already available.
REQ-012 full  output  1  all DEPTH entries are valid.
REQ-013 count  output  3  number of valid entries, 0..DEPTH.
REQ-014 cdb_valid  input  1  CDB broadcast present.
REQ-015 cdb_tag  input  TAG_W  broadcast tag.
REQ-016 cdb_data  input  32  broadcast result.
REQ-017 issue_valid  output  1  selected entry has both operands ready.
REQ-018 issue_opcode / issue_rd_tag / issue_rs_data / issue_rt_data  output  3/TAG_W/32/32  fields of the selected entry.
REQ-019 issue_rdy  input  1  ALU accepts; an issue fires when issue_valid and issue_rdy are both 1.

Function
REQ-020 Each entry holds: valid, opcode, rd_tag, rs/rt data, rs/rt tag, and rs/rt ready.
REQ-021 Select is the lowest-index valid entry with both ready bits set; issue_* outputs are combinational from the registered entry state.
REQ-022 When no entry is selectable, issue_valid is 0 and the other issue_* outputs are 0.
REQ-023 Wakeup: at each edge with cdb_valid=1, every valid entry operand with ready=0 and tag==cdb_tag sets ready=1 and captures cdb_data.
REQ-024 Wakeup latency is one cycle: cdb_data is never forwarded to issue_* in the broadcast cycle.
REQ-025 On a fired issue, entries above the issued index shift down one place, so age order is preserved.
REQ-026 Wakeup also applies to entries while they shift.
REQ-027 Dispatch is accepted only when dispatch_en=1, full=0 and flush=0; dispatch_en while full is ignored, even if an issue fires in the same cycle.
REQ-028 An accepted instruction is written to index count, or to count-1 if an issue fires in the same cycle.
REQ-029 Dispatch/CDB collision: if a dispatched operand has ready=0 and its tag matches a valid CDB broadcast in the same cycle, the operand is written with ready=1 and data=cdb_data.
REQ-030 count at the next edge = count + accepted dispatch - fired issue; full = (count==DEPTH).
REQ-031 flush has priority over dispatch, issue and wakeup: it clears all valid bits at the next edge.
REQ-032 During flush, issue_valid still reflects the current state; the downstream ALU is responsible for discarding.
REQ-033 Tag equality is an exact TAG_W-bit compare; a ready operand never compares against the CDB.

Reset
REQ-034 While rst=1: all valid bits are 0, count=0, full=0, issue_valid=0, and all issue_* data outputs are 0.
REQ-035 Entry payload fields need not be reset.
REQ-036 An rst assertion mid-operation discards all entries immediately (asynchronously).

Verification
REQ-037 Reset then one dispatch (opcode 3'd2, rd_tag 5, rs ready data 10, rt ready data 20) -> the next cycle issue_valid=1, issue_rs_data=10, issue_rt_data=20, issue_rd_tag=5, count=1.
REQ-038 Dispatch with rt_ready=0, rt_tag 7; CDB broadcasts tag 7, data 0xABCD one cycle later -> issue_valid=0 in the broadcast cycle and 1 in the following cycle with issue_rt_data=0xABCD.
REQ-039 Dispatch with rs_tag 9 not ready while CDB broadcasts tag 9, data 0x55 in the same cycle -> the entry issues the next cycle with rs_data=0x55.
REQ-040 Fill four entries with issue_rdy=0 -> full=1, count=4; a fifth dispatch is dropped; then issue_rdy=1 with only entry 2 ready -> entry 2 issues, old entry 3 moves to index 2, count=3.
REQ-041 Queue at count=2 with one issue firing and a dispatch in the same cycle -> count stays 2 and the new instruction occupies index 1.
REQ-042 Flush asserted together with dispatch_en at count=3 -> next cycle count=0, full=0, issue_valid=0.
